// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO pair.
// One product or quotient bit per enabled cycle; sign fix-up happens in a final FIX cycle.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi;   // upper partial product or running remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier bits / dividend bits being replaced by quotient bits
  logic             is_div;
  logic             neg_lo;
  logic             neg_hi;

  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic             last_iter;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  // Odd opcodes (MULTU, DIVU) are the unsigned flavours.
  assign op_signed = ~op[0];
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign b_zero    = (b == '0);
  assign last_iter = (count == CW'(WIDTH - 1));

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  // The remainder is always below the divisor, so a borrow out of the top bit means "restore".
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ok    = ~div_diff[WIDTH];

  assign prod      = {acc_hi, acc_lo};
  assign prod_fix  = neg_lo ? -prod : prod;

  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           state <= IDLE;
    else if (clk_enable)  state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start && !op[2] && !(op[1] && b_zero))
              state_next = op[1] ? DIV : MUL;
      MUL,
      DIV:  if (last_iter) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      count       <= '0;
      opnd        <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
    end else if (clk_enable) begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              opnd   <= a_mag;
              acc_hi <= '0;
              acc_lo <= b_mag;
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= a_neg ^ b_neg;
              is_div <= 1'b0;
              count  <= '0;
            end
            OP_DIV, OP_DIVU: begin
              if (b_zero) begin
                hi          <= a;
                lo          <= '1;
                done        <= 1'b1;
                div_by_zero <= 1'b1;
              end else begin
                opnd   <= b_mag;
                acc_hi <= '0;
                acc_lo <= a_mag;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg;
                is_div <= 1'b1;
                count  <= '0;
              end
            end
            OP_MTHI: begin
              hi   <= a;
              done <= 1'b1;
            end
            OP_MTLO: begin
              lo   <= a;
              done <= 1'b1;
            end
            default: ;
          endcase
        end
        MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          count  <= count + 1'b1;
        end
        DIV: begin
          acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          count  <= count + 1'b1;
        end
        FIX: begin
          if (is_div) begin
            hi <= neg_hi ? -acc_hi : acc_hi;
            lo <= neg_lo ? -acc_lo : acc_lo;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: directed corner cases, stall/reset timing,
// and randomized ops checked against an arithmetic reference model.
module tb_mips_muldiv_unit;

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic        clk_enable = 1'b1;
  logic        start      = 1'b0;
  logic [2:0]  op         = 3'b000;
  logic [31:0] a          = '0;
  logic [31:0] b          = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, want);
    end
  endtask

  // Architectural result of one issued op, from plain integer arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, p, q, r;
    logic [63:0] u;
    logic        dbz;
    logic        produces;
    dbz      = 1'b0;
    produces = 1'b1;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin u = {32'b0, x} * {32'b0, y}; m_hi = u[63:32]; m_lo = u[31:0]; end
      3'd2, 3'd3: begin
        if (y == 0) begin
          m_hi = x; m_lo = 32'hFFFF_FFFF; dbz = 1'b1;
        end else if (o == 3'd2) begin
          q = sx / sy; r = sx % sy;
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          m_lo = x / y; m_hi = x % y;
        end
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: produces = 1'b0;
    endcase
    if (produces) sb.push_back('{hi: m_hi, lo: m_lo, dbz: dbz});
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=done_high expected=no_pending_op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_hi",  hi, e.hi);
        check("sb_lo",  lo, e.lo);
        check("sb_dbz", div_by_zero, e.dbz);
      end
    end else if (reset && div_by_zero) begin
      checks++;
      errors++;
      $display("FAIL dbz_without_done actual=1 expected=0");
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that sampled start.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int g = 0;
    while (busy && g < 200) begin @(posedge clk); #1; g++; end
    if (busy) check("issue_wait_timeout", busy, 0);
    op = o; a = x; b = y; start = 1'b1;
    model(o, x, y);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || sb.size() != 0) && g < 200) begin @(posedge clk); #1; g++; end
    check("idle_timeout", (busy || sb.size() != 0), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [2:0]  ro;
    logic [31:0] rx, ry;

    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dbz",  div_by_zero, 0);
    check("reset_hi",   hi, 0);
    check("reset_lo",   lo, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // MULTU max*max with busy-length measurement.
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    while (busy && n < 200) begin @(negedge clk); if (busy) n++; end
    check("multu_busy_cycles", n, 33);
    check("done_at_busy_fall", done, 1);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    @(posedge clk); #1;
    check("done_single_cycle", done, 0);

    issue(3'd0, 32'hFFFF_FFFD, 32'd7);           wait_idle();
    issue(3'd0, 32'h8000_0000, 32'h8000_0000);   wait_idle();
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);           wait_idle();
    check("div_neg7_lo", lo, 32'hFFFF_FFFD);
    check("div_neg7_hi", hi, 32'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);   wait_idle();
    check("div_min_lo", lo, 32'h8000_0000);
    check("div_min_hi", hi, 32'h0000_0000);
    issue(3'd3, 32'd100, 32'd7);                 wait_idle();

    // Divide by zero completes on edge 0 without busy.
    issue(3'd3, 32'd100, 32'd0);
    check("dbz_busy", busy, 0);
    check("dbz_done", done, 1);
    check("dbz_flag", div_by_zero, 1);
    @(posedge clk); #1;
    check("dbz_done_clear", done, 0);
    check("dbz_flag_clear", div_by_zero, 0);
    check("dbz_hi", hi, 32'd100);
    check("dbz_lo", lo, 32'hFFFF_FFFF);

    // Back-to-back moves.
    issue(3'd4, 32'h0000_1234, 32'd0);
    issue(3'd5, 32'h0000_5678, 32'd0);
    wait_idle();
    check("mthi_hi", hi, 32'h0000_1234);
    check("mtlo_lo", lo, 32'h0000_5678);

    // Stall: clock enable low for 5 edges, plus a dropped start while busy.
    issue(3'd1, 32'd3, 32'd5);
    n = 0;
    while (!done && n < 100) begin
      if (n == 5)  begin op = 3'd1; a = 32'd7; b = 32'd9; start = 1'b1; end
      if (n == 6)  start = 1'b0;
      if (n == 10) clk_enable = 1'b0;
      if (n == 15) clk_enable = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check("stall_latency", n, 38);
    wait_idle();
    check("stall_hi", hi, 32'd0);
    check("stall_lo", lo, 32'd15);

    // Randomized ops, including unused opcodes and sign/zero corners.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       ry = 32'd0;
        1:       ry = 32'hFFFF_FFFF;
        2:       ry = 32'h8000_0000;
        3:       ry = $urandom_range(1, 20);
        default: ry = $urandom;
      endcase
      issue(ro, rx, ry);
    end
    wait_idle();
    check("random_final_hi", hi, m_hi);
    check("random_final_lo", lo, m_lo);

    // Asynchronous reset mid-divide.
    issue(3'd2, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi",   hi, 0);
    check("abort_lo",   lo, 0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    issue(3'd0, 32'd2, 32'd3);
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    check("post_reset_latency", n, 33);
    wait_idle();
    check("post_reset_lo", lo, 32'd6);
    check("post_reset_hi", hi, 32'd0);

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
